vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 149 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/SVGA raster timing generator.
// Produces raw raster position, active-area pixel coordinates, sync pulses,
// display-enable, vertical blanking and line/frame start strobes. Each axis
// is ordered sync, back porch, active, front porch. Every output is
// registered and decoded from the next-state counters, so all outputs in a
// cycle describe the same (hpos, vpos) point.
//
// Ports:
//   clk         pixel/system clock
//   clr         synchronous active-low reset
//   ce          pixel advance enable (tie high for a 1:1 pixel clock)
//   hpos/vpos   raw raster position
//   pixh/pixv   active-area coordinates, 0 outside the active area
//   hsync/vsync sync outputs, active level set by HS_POL/VS_POL
//   de          display enable
//   vblank      high outside the vertical active lines
//   line_start  one-clock strobe at hpos==0
//   frame_start one-clock strobe at hpos==0, vpos==0
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = 11
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          ce,
  output logic [CW-1:0] hpos,
  output logic [CW-1:0] vpos,
  output logic [CW-1:0] pixh,
  output logic [CW-1:0] pixv,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          vblank,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned H_ACT_FIRST = H_SYNC + H_BP;
  localparam int unsigned H_ACT_LAST  = H_ACT_FIRST + H_ACTIVE - 1;
  localparam int unsigned V_ACT_FIRST = V_SYNC + V_BP;
  localparam int unsigned V_ACT_LAST  = V_ACT_FIRST + V_ACTIVE - 1;

  // Refuse to elaborate when the raster cannot be counted in CW bits.
  if ((((H_TOTAL - 1) >> CW) != 0) || (((V_TOTAL - 1) >> CW) != 0)) begin : g_cw_too_small
    $error("vga_timing_gen: H_TOTAL-1 or V_TOTAL-1 does not fit in CW bits");
  end

  logic [CW-1:0] hpos_q, hpos_d;
  logic [CW-1:0] vpos_q, vpos_d;
  logic [CW-1:0] pixh_q, pixh_d;
  logic [CW-1:0] pixv_q, pixv_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic          vblank_q, vblank_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          h_in, v_in;

  // Next position and its decode; everything holds when ce is low except
  // the strobes, which drop so they fire once per line/frame.
  always_comb begin
    hpos_d        = hpos_q;
    vpos_d        = vpos_q;
    pixh_d        = pixh_q;
    pixv_d        = pixv_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    vblank_d      = vblank_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    h_in          = 1'b0;
    v_in          = 1'b0;

    if (ce) begin
      if (hpos_q == CW'(H_TOTAL - 1)) begin
        hpos_d = '0;
        vpos_d = (vpos_q == CW'(V_TOTAL - 1)) ? '0 : vpos_q + CW'(1);
      end else begin
        hpos_d = hpos_q + CW'(1);
      end

      h_in = (hpos_d >= CW'(H_ACT_FIRST)) && (hpos_d <= CW'(H_ACT_LAST));
      v_in = (vpos_d >= CW'(V_ACT_FIRST)) && (vpos_d <= CW'(V_ACT_LAST));

      hsync_d       = (hpos_d < CW'(H_SYNC)) ? HS_POL : ~HS_POL;
      vsync_d       = (vpos_d < CW'(V_SYNC)) ? VS_POL : ~VS_POL;
      de_d          = h_in && v_in;
      vblank_d      = ~v_in;
      // Subtraction cannot underflow while de is high.
      pixh_d        = de_d ? hpos_d - CW'(H_ACT_FIRST) : '0;
      pixv_d        = de_d ? vpos_d - CW'(V_ACT_FIRST) : '0;
      line_start_d  = (hpos_d == '0);
      frame_start_d = (hpos_d == '0) && (vpos_d == '0);
    end
  end

  // State/output registers; reset parks on the last raster point so the
  // first enabled pixel after release is (0,0).
  always_ff @(posedge clk) begin
    if (!clr) begin
      hpos_q        <= CW'(H_TOTAL - 1);
      vpos_q        <= CW'(V_TOTAL - 1);
      pixh_q        <= '0;
      pixv_q        <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      vblank_q      <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      pixh_q        <= pixh_d;
      pixv_q        <= pixv_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      vblank_q      <= vblank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign pixh        = pixh_q;
  assign pixv        = pixv_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign vblank      = vblank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-parameter instance and a tiny
// overridden instance run side by side against a raster model that tracks
// a linear pixel index per frame.
module tb_vga_timing_gen;

  typedef struct packed {
    int hs; int hb; int ha; int hf;
    int vs; int vb; int va; int vf;
    bit hp; bit vp;
  } timing_t;

  typedef struct packed {
    int h; int v; bit ls; bit fs;
  } mstate_t;

  localparam timing_t TA = '{hs:128, hb:88, ha:800, hf:40, vs:4, vb:23, va:600, vf:1, hp:1'b0, vp:1'b0};
  localparam timing_t TB = '{hs:1, hb:1, ha:4, hf:1, vs:1, vb:1, va:2, vf:1, hp:1'b1, vp:1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_clr, a_ce, b_clr, b_ce;
  logic [10:0] a_hpos, a_vpos, a_pixh, a_pixv;
  logic        a_hsync, a_vsync, a_de, a_vblank, a_ls, a_fs;
  logic [3:0]  b_hpos, b_vpos, b_pixh, b_pixv;
  logic        b_hsync, b_vsync, b_de, b_vblank, b_ls, b_fs;

  vga_timing_gen u_dut_a (
    .clk(clk), .clr(a_clr), .ce(a_ce),
    .hpos(a_hpos), .vpos(a_vpos), .pixh(a_pixh), .pixv(a_pixv),
    .hsync(a_hsync), .vsync(a_vsync), .de(a_de), .vblank(a_vblank),
    .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(4)
  ) u_dut_b (
    .clk(clk), .clr(b_clr), .ce(b_ce),
    .hpos(b_hpos), .vpos(b_vpos), .pixh(b_pixh), .pixv(b_pixv),
    .hsync(b_hsync), .vsync(b_vsync), .de(b_de), .vblank(b_vblank),
    .line_start(b_ls), .frame_start(b_fs)
  );

  int      n_pass = 0;
  int      n_fail = 0;
  int      n_total = 0;
  int      cyc = 0;
  mstate_t ma, mb;
  int      a_last = -1;
  int      a_per_exp = 0;
  int      b_last = -1;
  int      b_lines = 0;
  bit      b_meas = 1'b0;

  // Raster model: the position is an index into the frame, advanced mod frame size.
  function automatic mstate_t step(mstate_t s, bit clr, bit ce, timing_t t);
    int ht, vt, idx;
    ht = t.hs + t.hb + t.ha + t.hf;
    vt = t.vs + t.vb + t.va + t.vf;
    s.ls = 1'b0;
    s.fs = 1'b0;
    if (!clr) begin
      s.h = ht - 1;
      s.v = vt - 1;
    end else if (ce) begin
      idx  = (s.v * ht + s.h + 1) % (ht * vt);
      s.h  = idx % ht;
      s.v  = idx / ht;
      s.ls = (s.h == 0);
      s.fs = (idx == 0);
    end
    return s;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_dut(input string p, input mstate_t s, input timing_t t,
                           input logic [31:0] hpos, input logic [31:0] vpos,
                           input logic [31:0] pixh, input logic [31:0] pixv,
                           input logic hs, input logic vs, input logic de,
                           input logic vb, input logic ls, input logic fs);
    bit hin, vin, e_de;
    hin  = (s.h >= t.hs + t.hb) && (s.h < t.hs + t.hb + t.ha);
    vin  = (s.v >= t.vs + t.vb) && (s.v < t.vs + t.vb + t.va);
    e_de = hin && vin;
    cmp({p, "_hpos"},   hpos, s.h);
    cmp({p, "_vpos"},   vpos, s.v);
    cmp({p, "_pixh"},   pixh, e_de ? s.h - (t.hs + t.hb) : 0);
    cmp({p, "_pixv"},   pixv, e_de ? s.v - (t.vs + t.vb) : 0);
    cmp({p, "_hsync"},  {31'd0, hs}, {31'd0, (s.h < t.hs) ? t.hp : !t.hp});
    cmp({p, "_vsync"},  {31'd0, vs}, {31'd0, (s.v < t.vs) ? t.vp : !t.vp});
    cmp({p, "_de"},     {31'd0, de}, {31'd0, e_de});
    cmp({p, "_vblank"}, {31'd0, vb}, {31'd0, !vin});
    cmp({p, "_line_start"},  {31'd0, ls}, {31'd0, s.ls});
    cmp({p, "_frame_start"}, {31'd0, fs}, {31'd0, s.fs});
  endtask

  // One clock: advance both models, then sample #1 after the edge.
  task automatic tick();
    @(posedge clk);
    ma = step(ma, a_clr, a_ce, TA);
    mb = step(mb, b_clr, b_ce, TB);
    cyc++;
    #1;
    check_dut("a", ma, TA, 32'(a_hpos), 32'(a_vpos), 32'(a_pixh), 32'(a_pixv),
              a_hsync, a_vsync, a_de, a_vblank, a_ls, a_fs);
    check_dut("b", mb, TB, 32'(b_hpos), 32'(b_vpos), 32'(b_pixh), 32'(b_pixv),
              b_hsync, b_vsync, b_de, b_vblank, b_ls, b_fs);
    if (a_ls === 1'b1) begin
      cmp("a_strobe_on_ce", {31'd0, a_ce}, 32'd1);
      if (a_per_exp != 0 && a_last >= 0) cmp("a_line_period", cyc - a_last, a_per_exp);
      a_last = cyc;
    end
    if (b_fs === 1'b1) begin
      if (b_meas && b_last >= 0) begin
        cmp("b_frame_period", cyc - b_last, 35);
        cmp("b_lines_per_frame", b_lines, 5);
      end
      b_last  = cyc;
      b_lines = 0;
    end
    if (b_ls === 1'b1) b_lines++;
  endtask

  // Run instance A until its model reaches (h,v), bounded.
  task automatic wait_pos(input int h, input int v);
    int k;
    k = 0;
    while (!(ma.h == h && ma.v == v) && k < 40000) begin
      tick();
      k++;
    end
    cmp("a_wait_hpos", 32'(a_hpos), h);
    cmp("a_wait_vpos", 32'(a_vpos), v);
  endtask

  initial begin
    ma = '{h:0, v:0, ls:1'b0, fs:1'b0};
    mb = '{h:0, v:0, ls:1'b0, fs:1'b0};
    a_clr = 1'b0; a_ce = 1'b1;
    b_clr = 1'b0; b_ce = 1'b1;

    // Reset with ce high: reset values only.
    repeat (3) tick();
    cmp("a_rst_hpos", 32'(a_hpos), 1055);
    cmp("a_rst_vpos", 32'(a_vpos), 627);
    cmp("a_rst_hsync", {31'd0, a_hsync}, 1);
    cmp("a_rst_vsync", {31'd0, a_vsync}, 1);
    cmp("a_rst_de", {31'd0, a_de}, 0);
    cmp("a_rst_vblank", {31'd0, a_vblank}, 1);
    cmp("b_rst_hpos", 32'(b_hpos), 6);
    cmp("b_rst_vpos", 32'(b_vpos), 4);
    cmp("b_rst_hsync", {31'd0, b_hsync}, 0);

    // First enabled clock lands on (0,0).
    a_clr = 1'b1; b_clr = 1'b1; b_meas = 1'b1; a_per_exp = 1056;
    tick();
    cmp("a_first_hpos", 32'(a_hpos), 0);
    cmp("a_first_vpos", 32'(a_vpos), 0);
    cmp("a_first_fs", {31'd0, a_fs}, 1);
    cmp("a_first_ls", {31'd0, a_ls}, 1);
    cmp("a_first_hsync", {31'd0, a_hsync}, 0);
    cmp("a_first_vsync", {31'd0, a_vsync}, 0);
    cmp("b_first_hsync", {31'd0, b_hsync}, 1);

    wait_pos(128, 0);
    cmp("a_hsync_end", {31'd0, a_hsync}, 1);
    wait_pos(1055, 3);
    cmp("a_vsync_line3", {31'd0, a_vsync}, 0);
    tick();
    cmp("a_wrap_vpos", 32'(a_vpos), 4);
    cmp("a_vsync_end", {31'd0, a_vsync}, 1);

    wait_pos(216, 27);
    cmp("a_de_first", {31'd0, a_de}, 1);
    cmp("a_pixh_first", 32'(a_pixh), 0);
    cmp("a_pixv_first", 32'(a_pixv), 0);
    wait_pos(1015, 27);
    cmp("a_pixh_last", 32'(a_pixh), 799);
    tick();
    cmp("a_de_after", {31'd0, a_de}, 0);
    cmp("a_pixh_after", 32'(a_pixh), 0);

    // Mid-frame reset with random ce.
    wait_pos(500, 28);
    a_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_ce = 1'($urandom_range(0, 1));
      tick();
    end
    cmp("a_mid_rst_hsync", {31'd0, a_hsync}, 1);
    cmp("a_mid_rst_de", {31'd0, a_de}, 0);
    cmp("a_mid_rst_vblank", {31'd0, a_vblank}, 1);
    cmp("a_mid_rst_hpos", 32'(a_hpos), 1055);
    a_clr = 1'b1; a_ce = 1'b0;
    repeat (2) tick();
    a_ce = 1'b1; a_last = -1;
    tick();
    cmp("a_rel_hpos", 32'(a_hpos), 0);
    cmp("a_rel_vpos", 32'(a_vpos), 0);
    cmp("a_rel_fs", {31'd0, a_fs}, 1);

    // ce on every other clock: line period doubles.
    a_per_exp = 2112;
    for (int i = 0; i < 3 * 2112 + 8; i++) begin
      a_ce = ~a_ce;
      tick();
    end

    // Random ce and occasional resets on both instances.
    a_per_exp = 0; b_meas = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      a_ce  = 1'($urandom_range(0, 1));
      a_clr = ($urandom_range(0, 2047) != 0);
      b_ce  = ($urandom_range(0, 3) != 0);
      b_clr = ($urandom_range(0, 63) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
